// File: rtl/btn_debounce_pair.sv
// Two-channel button conditioner: 2-FF synchronizer, then a per-channel debounce FSM
// that drives registered levels and single-cycle rise/fall strobes.
module btn_debounce_pair #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_A,
  input  logic BTN_B,
  output logic A,
  output logic B,
  output logic A_RISE,
  output logic A_FALL,
  output logic B_RISE,
  output logic B_FALL,
  output logic BUSY
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0] btn_raw;
  logic [1:0] level_w;
  logic [1:0] rise_w;
  logic [1:0] fall_w;
  logic [1:0] waiting_w;

  assign btn_raw = {BTN_B, BTN_A};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic             s1_q;
      logic             s_q;
      state_t           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             level_q;
      logic             rise_q;
      logic             fall_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s1_q <= 1'b0;
          s_q  <= 1'b0;
        end else begin
          s1_q <= btn_raw[gi];
          s_q  <= s1_q;
        end
      end

      // The counter only advances inside WAIT_* and is cleared on every exit,
      // so it tops out at DEBOUNCE_CYCLES-1 and never wraps.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
          level_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          case (state_q)
            STABLE_LO: begin
              if (s_q) begin
                state_q <= WAIT_HI;
                cnt_q   <= CNT_ONE;
              end else begin
                cnt_q <= '0;
              end
            end
            WAIT_HI: begin
              if (!s_q) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
              end else if (cnt_q == CNT_LAST) begin
                state_q <= STABLE_HI;
                level_q <= 1'b1;
                rise_q  <= 1'b1;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
            STABLE_HI: begin
              if (!s_q) begin
                state_q <= WAIT_LO;
                cnt_q   <= CNT_ONE;
              end else begin
                cnt_q <= '0;
              end
            end
            WAIT_LO: begin
              if (s_q) begin
                state_q <= STABLE_HI;
                cnt_q   <= '0;
              end else if (cnt_q == CNT_LAST) begin
                state_q <= STABLE_LO;
                level_q <= 1'b0;
                fall_q  <= 1'b1;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
            default: begin
              state_q <= STABLE_LO;
              cnt_q   <= '0;
            end
          endcase
        end
      end

      assign level_w[gi]   = level_q;
      assign rise_w[gi]    = rise_q;
      assign fall_w[gi]    = fall_q;
      assign waiting_w[gi] = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    end
  endgenerate

  assign A      = level_w[0];
  assign B      = level_w[1];
  assign A_RISE = rise_w[0];
  assign A_FALL = fall_w[0];
  assign B_RISE = rise_w[1];
  assign B_FALL = fall_w[1];
  assign BUSY   = |waiting_w;

endmodule

// File: tb/tb_btn_debounce_pair.sv
// Bench for btn_debounce_pair (DEBOUNCE_CYCLES=4): directed stimulus queues expected
// strobe events; a negedge monitor matches every strobe cycle against the queue.
module tb_btn_debounce_pair;

  localparam int DC = 4;
  localparam logic [3:0] S_AR = 4'b1000;
  localparam logic [3:0] S_AF = 4'b0100;
  localparam logic [3:0] S_BR = 4'b0010;
  localparam logic [3:0] S_BF = 4'b0001;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic BTN_A = 1'b0;
  logic BTN_B = 1'b0;
  logic A, B, A_RISE, A_FALL, B_RISE, B_FALL, BUSY;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] stb;
    logic       a;
    logic       b;
  } exp_t;

  exp_t exp_q[$];

  btn_debounce_pair #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(16)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .BTN_A(BTN_A),
    .BTN_B(BTN_B),
    .A(A),
    .B(B),
    .A_RISE(A_RISE),
    .A_FALL(A_FALL),
    .B_RISE(B_RISE),
    .B_FALL(B_FALL),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // cyc holds the number of rising edges seen so far.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] stb, input logic a, input logic b);
    exp_t e;
    e.cyc = c;
    e.stb = stb;
    e.a   = a;
    e.b   = b;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: any strobe must match the head of the queue; an overdue head is a miss.
  always @(negedge CLK) begin
    logic [3:0] stb;
    exp_t e;
    stb = {A_RISE, A_FALL, B_RISE, B_FALL};
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event cycle=%0d got=none expected stb=%b at cycle %0d", cyc, e.stb, e.cyc);
    end
    if (stb !== 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cycle=%0d got stb=%b A=%b B=%b expected=none", cyc, stb, A, B);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || stb !== e.stb || A !== e.a || B !== e.b) begin
          errors++;
          $display("FAIL strobe_event got cycle=%0d stb=%b A=%b B=%b expected cycle=%0d stb=%b A=%b B=%b",
                   cyc, stb, A, B, e.cyc, e.stb, e.a, e.b);
        end else begin
          $display("event cycle=%0d stb=%b A=%b B=%b ok", cyc, stb, A, B);
        end
      end
    end
  end

  initial begin
    int c;
    int r;
    int bv[6];
    bv = '{1, 0, 1, 1, 0, 1};

    // Reset held across edges
    tick(2);
    chk("reset_A", A, 0);
    chk("reset_B", B, 0);
    chk("reset_strobes", {A_RISE, A_FALL, B_RISE, B_FALL}, 0);
    chk("reset_BUSY", BUSY, 0);
    RST_N = 1'b1;
    tick(2);
    chk("idle_BUSY", BUSY, 0);

    // Clean press on A
    c = cyc;
    BTN_A = 1'b1;
    push(c + 6, S_AR, 1'b1, 1'b0);
    tick(5);
    chk("press_A_before", A, 0);
    chk("press_BUSY", BUSY, 1);
    tick(1);
    chk("press_A_level", A, 1);
    chk("press_A_RISE", A_RISE, 1);
    tick(1);
    chk("press_A_RISE_clear", A_RISE, 0);
    chk("press_B_quiet", {B, B_RISE, B_FALL}, 0);
    tick(3);
    chk("press_A_hold", A, 1);

    // Release A
    c = cyc;
    BTN_A = 1'b0;
    push(c + 6, S_AF, 1'b0, 1'b0);
    tick(8);
    chk("release_A", A, 0);
    chk("release_BUSY", BUSY, 0);

    // Three synchronized samples: rejected
    c = cyc;
    BTN_A = 1'b1;
    tick(3);
    BTN_A = 1'b0;
    chk("thr3_BUSY_a", BUSY, 1);
    tick(2);
    chk("thr3_BUSY_b", BUSY, 1);
    tick(1);
    chk("thr3_BUSY_end", BUSY, 0);
    chk("thr3_A", A, 0);
    tick(4);

    // Four synchronized samples: accepted, then released
    c = cyc;
    BTN_A = 1'b1;
    push(c + 6, S_AR, 1'b1, 1'b0);
    tick(4);
    BTN_A = 1'b0;
    push(c + 10, S_AF, 1'b0, 1'b0);
    tick(3);
    chk("thr4_A", A, 1);
    tick(5);
    chk("thr4_A_after", A, 0);

    // Bouncing B
    for (int i = 0; i < 6; i++) begin
      BTN_B = bv[i][0];
      if (i < 5) tick(1);
    end
    c = cyc;
    push(c + 6, S_BR, 1'b0, 1'b1);
    tick(8);
    chk("bounce_B", B, 1);
    chk("bounce_BUSY", BUSY, 0);

    // Press A too, then release both together
    c = cyc;
    BTN_A = 1'b1;
    push(c + 6, S_AR, 1'b1, 1'b1);
    tick(8);
    chk("both_and_hi", A & B, 1);
    c = cyc;
    BTN_A = 1'b0;
    BTN_B = 1'b0;
    push(c + 6, S_AF | S_BF, 1'b0, 1'b0);
    tick(5);
    chk("simul_and_before", A & B, 1);
    tick(1);
    chk("simul_and_after", A & B, 0);
    chk("simul_falls", {A_FALL, B_FALL}, 2'b11);
    tick(3);

    // Both high, then asynchronous reset between edges
    c = cyc;
    BTN_A = 1'b1;
    BTN_B = 1'b1;
    push(c + 6, S_AR | S_BR, 1'b1, 1'b1);
    tick(8);
    chk("prereset_AB", {A, B}, 2'b11);
    #1;
    RST_N = 1'b0;
    #1;
    chk("async_reset_AB", {A, B}, 0);
    chk("async_reset_strobes", {A_RISE, A_FALL, B_RISE, B_FALL}, 0);
    chk("async_reset_BUSY", BUSY, 0);
    tick(2);
    r = cyc;
    RST_N = 1'b1;
    push(r + 6, S_AR | S_BR, 1'b1, 1'b1);
    tick(5);
    chk("requal_A_before", A, 0);
    chk("requal_BUSY", BUSY, 1);
    tick(3);
    chk("requal_AB", {A, B}, 2'b11);
    c = cyc;
    BTN_A = 1'b0;
    BTN_B = 1'b0;
    push(c + 6, S_AF | S_BF, 1'b0, 1'b0);
    tick(8);

    // Reset while A is qualifying at cnt=2
    BTN_A = 1'b1;
    tick(4);
    chk("midq_BUSY", BUSY, 1);
    RST_N = 1'b0;
    #1;
    chk("midq_reset_A", A, 0);
    chk("midq_reset_BUSY", BUSY, 0);
    tick(2);
    chk("midq_no_rise", {A, A_RISE}, 0);
    r = cyc;
    RST_N = 1'b1;
    push(r + 6, S_AR, 1'b1, 1'b0);
    tick(8);
    chk("midq_A", A, 1);
    c = cyc;
    BTN_A = 1'b0;
    push(c + 6, S_AF, 1'b0, 1'b0);
    tick(10);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
